// File: rtl/debounce_filter.sv
// Synchroniser plus four-state debounce filter for one raw asynchronous input.
// Define DEBOUNCE_EDGE_PULSE_EN to add the registered rise_p/fall_p edge pulses.
module debounce_filter #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 16,
    parameter int STABLE_CNT  = 1000,
    parameter int INIT_LEVEL  = 0
) (
    input  logic       clk,
    input  logic       Reset,
    input  logic       en,
    input  logic       din,
    output logic       dout,
    output logic       dout_n,
    output logic       busy,
    output logic [7:0] glitch_cnt
`ifdef DEBOUNCE_EDGE_PULSE_EN
    ,
    output logic       rise_p,
    output logic       fall_p
`endif
);

    // Bit 0 of the encoding marks the qualifying states, so busy is a plain register bit.
    typedef enum logic [1:0] {
        STABLE_LO = 2'b00,
        WAIT_HI   = 2'b01,
        STABLE_HI = 2'b10,
        WAIT_LO   = 2'b11
    } state_e;

    localparam logic             INIT_BIT    = (INIT_LEVEL != 0);
    localparam state_e           RESET_STATE = INIT_BIT ? STABLE_HI : STABLE_LO;
    localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(STABLE_CNT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};

    if ((SYNC_STAGES < 2) || (SYNC_STAGES > 4)) begin : g_bad_sync
        $error("debounce_filter: SYNC_STAGES must be in 2..4");
    end
    if ((STABLE_CNT < 1) || (longint'(STABLE_CNT) > ((longint'(1) << CNT_W) - longint'(1)))) begin : g_bad_cnt
        $error("debounce_filter: STABLE_CNT must be in 1..2^CNT_W-1");
    end
    if ((INIT_LEVEL != 0) && (INIT_LEVEL != 1)) begin : g_bad_init
        $error("debounce_filter: INIT_LEVEL must be 0 or 1");
    end

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : (v + 8'd1);
    endfunction

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   dout_q, dout_d;
    logic                   dout_n_q, dout_n_d;
    logic [7:0]             glitch_q, glitch_d;

    assign s = sync_q[SYNC_STAGES-1];

    // Synchroniser shift chain, clocked every cycle independent of en.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            sync_q <= {SYNC_STAGES{INIT_BIT}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
        end
    end

    // Next-state logic; an abort is tested before count completion and ignores en.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        dout_d   = dout_q;
        dout_n_d = dout_n_q;
        glitch_d = glitch_q;
        case (state_q)
            STABLE_LO: begin
                if (s) begin
                    state_d = WAIT_HI;
                    cnt_d   = {CNT_W{1'b0}};
                end else begin
                    state_d = STABLE_LO;
                end
            end
            WAIT_HI: begin
                if (!s) begin
                    state_d  = STABLE_LO;
                    glitch_d = sat_inc8(glitch_q);
                end else if (en && (cnt_q == CNT_LAST)) begin
                    state_d  = STABLE_HI;
                    dout_d   = 1'b1;
                    dout_n_d = 1'b0;
                end else if (en) begin
                    cnt_d = cnt_q + CNT_ONE;
                end else begin
                    cnt_d = cnt_q;
                end
            end
            STABLE_HI: begin
                if (!s) begin
                    state_d = WAIT_LO;
                    cnt_d   = {CNT_W{1'b0}};
                end else begin
                    state_d = STABLE_HI;
                end
            end
            WAIT_LO: begin
                if (s) begin
                    state_d  = STABLE_HI;
                    glitch_d = sat_inc8(glitch_q);
                end else if (en && (cnt_q == CNT_LAST)) begin
                    state_d  = STABLE_LO;
                    dout_d   = 1'b0;
                    dout_n_d = 1'b1;
                end else if (en) begin
                    cnt_d = cnt_q + CNT_ONE;
                end else begin
                    cnt_d = cnt_q;
                end
            end
            default: begin
                state_d  = RESET_STATE;
                cnt_d    = {CNT_W{1'b0}};
                dout_d   = INIT_BIT;
                dout_n_d = ~INIT_BIT;
            end
        endcase
    end

    // Filter state, counter and output registers.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state_q  <= RESET_STATE;
            cnt_q    <= {CNT_W{1'b0}};
            dout_q   <= INIT_BIT;
            dout_n_q <= ~INIT_BIT;
            glitch_q <= 8'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            dout_q   <= dout_d;
            dout_n_q <= dout_n_d;
            glitch_q <= glitch_d;
        end
    end

    assign dout       = dout_q;
    assign dout_n     = dout_n_q;
    assign busy       = state_q[0];
    assign glitch_cnt = glitch_q;

`ifdef DEBOUNCE_EDGE_PULSE_EN
    logic rise_q, fall_q;

    // Edge pulses register in the same edge that updates dout.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            rise_q <= dout_d & ~dout_q;
            fall_q <= ~dout_d & dout_q;
        end
    end

    assign rise_p = rise_q;
    assign fall_p = fall_q;
`endif

endmodule
